// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: X = A + B*W, Y = A - B*W in signed fixed point with Q fractional bits.
// One multiplier is time-shared across the four real products, one product per state.
module fft_butterfly #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int SCALE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_ar,
    input  logic [N-1:0] i_ai,
    input  logic [N-1:0] i_br,
    input  logic [N-1:0] i_bi,
    input  logic [N-1:0] i_wr,
    input  logic [N-1:0] i_wi,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_xr,
    output logic [N-1:0] o_xi,
    output logic [N-1:0] o_yr,
    output logic [N-1:0] o_yi
);

    typedef enum logic [2:0] {
        StIdle,
        StMul0,
        StMul1,
        StMul2,
        StMul3,
        StAdd,
        StDone
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d, wr_q, wr_d, wi_q, wi_d;
    logic [N-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [N-1:0] xr_q, xr_d, xi_q, xi_d, yr_q, yr_d, yi_q, yi_d;
    logic         valid_q, valid_d;

    logic signed [N-1:0]   mul_a, mul_b;
    logic signed [2*N-1:0] prod;
    logic [N-1:0]          prod_t;
    logic [N:0]            tr, ti;

    function automatic logic [N-1:0] saturate(input logic signed [N+1:0] v);
        logic signed [N+1:0] max_v, min_v;
        max_v = {3'b000, {(N-1){1'b1}}};
        min_v = {3'b111, {(N-1){1'b0}}};
        if (v > max_v) begin
            return max_v[N-1:0];
        end else if (v < min_v) begin
            return min_v[N-1:0];
        end
        return v[N-1:0];
    endfunction

    // A +/- t with two guard bits so neither the sum nor the optional halving can wrap.
    function automatic logic [N-1:0] combine(input logic [N-1:0] a, input logic [N:0] t,
                                             input logic sub);
        logic signed [N+1:0] ae, te, s;
        ae = {{2{a[N-1]}}, a};
        te = {t[N], t};
        s  = sub ? (ae - te) : (ae + te);
        if (SCALE != 0) begin
            s = s >>> 1;
        end
        return saturate(s);
    endfunction

    always_comb begin
        mul_a = br_q;
        mul_b = wr_q;
        unique case (state_q)
            StMul1:  begin mul_a = bi_q; mul_b = wi_q; end
            StMul2:  begin mul_a = br_q; mul_b = wi_q; end
            StMul3:  begin mul_a = bi_q; mul_b = wr_q; end
            default: ;
        endcase
        prod   = mul_a * mul_b;
        // Floor-truncate the Q fractional bits; overflow wraps.
        prod_t = prod[N-1+Q:Q];
    end

    assign tr = {p0_q[N-1], p0_q} - {p1_q[N-1], p1_q};
    assign ti = {p2_q[N-1], p2_q} + {p3_q[N-1], p3_q};

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        wr_d    = wr_q;
        wi_d    = wi_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        yr_d    = yr_q;
        yi_d    = yi_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    ar_d    = i_ar;
                    ai_d    = i_ai;
                    br_d    = i_br;
                    bi_d    = i_bi;
                    wr_d    = i_wr;
                    wi_d    = i_wi;
                    state_d = StMul0;
                end
            end
            StMul0: begin p0_d = prod_t; state_d = StMul1; end
            StMul1: begin p1_d = prod_t; state_d = StMul2; end
            StMul2: begin p2_d = prod_t; state_d = StMul3; end
            StMul3: begin p3_d = prod_t; state_d = StAdd;  end
            StAdd: begin
                xr_d    = combine(ar_q, tr, 1'b0);
                xi_d    = combine(ai_q, ti, 1'b0);
                yr_d    = combine(ar_q, tr, 1'b1);
                yi_d    = combine(ai_q, ti, 1'b1);
                valid_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            wr_q    <= '0;
            wi_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            xr_q    <= '0;
            xi_q    <= '0;
            yr_q    <= '0;
            yi_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            wr_q    <= wr_d;
            wi_q    <= wi_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            yr_q    <= yr_d;
            yi_q    <= yi_d;
            valid_q <= valid_d;
        end
    end

    assign o_ready = (state_q == StIdle);
    assign o_valid = valid_q;
    assign o_xr    = xr_q;
    assign o_xi    = xi_q;
    assign o_yr    = yr_q;
    assign o_yi    = yi_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: two instances (SCALE=1 and SCALE=0) share stimulus and are checked
// every cycle against an integer-arithmetic butterfly model, plus hand-computed vectors.
module tb_fft_butterfly;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [15:0] ar = '0, ai = '0, br = '0, bi = '0, wr = '0, wi = '0;
    logic        rdy1, vld1, rdy0, vld0;
    logic [15:0] xr1, xi1, yr1, yi1, xr0, xi0, yr0, yi0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_butterfly #(.N(16), .Q(8), .SCALE(1)) u_s1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy1),
        .i_ar(ar), .i_ai(ai), .i_br(br), .i_bi(bi), .i_wr(wr), .i_wi(wi),
        .o_valid(vld1), .i_ready(i_ready),
        .o_xr(xr1), .o_xi(xi1), .o_yr(yr1), .o_yi(yi1)
    );

    fft_butterfly #(.N(16), .Q(8), .SCALE(0)) u_s0 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy0),
        .i_ar(ar), .i_ai(ai), .i_br(br), .i_bi(bi), .i_wr(wr), .i_wi(wi),
        .o_valid(vld0), .i_ready(i_ready),
        .o_xr(xr0), .o_xi(xi0), .o_yr(yr0), .o_yi(yi0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Q8.8 product, floored, wrapped to 16 bits.
    function automatic longint prodq(input logic [15:0] b, input logic [15:0] w);
        longint p;
        logic signed [15:0] p16;
        p   = longint'($signed(b)) * longint'($signed(w));
        p   = p >>> 8;
        p16 = p[15:0];
        return longint'(p16);
    endfunction

    function automatic logic [15:0] fin(input longint s, input bit scale);
        longint v;
        v = scale ? (s >>> 1) : s;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [63:0] butterfly(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                                              input bit scale);
        longint t_r, t_i, a_re, a_im;
        t_r  = prodq(b_r, w_r) - prodq(b_i, w_i);
        t_i  = prodq(b_r, w_i) + prodq(b_i, w_r);
        a_re = longint'($signed(a_r));
        a_im = longint'($signed(a_i));
        return {fin(a_re + t_r, scale), fin(a_im + t_i, scale),
                fin(a_re - t_r, scale), fin(a_im - t_i, scale)};
    endfunction

    // Transaction model: 0 idle, 1..5 busy, 6 holding a valid result.
    int          m_cnt = 0;
    logic [15:0] m_ar = '0, m_ai = '0, m_br = '0, m_bi = '0, m_wr = '0, m_wi = '0;
    logic [63:0] e1 = '0, e0 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            e1    <= '0;
            e0    <= '0;
        end else if (m_cnt == 0) begin
            if (i_valid) begin
                m_cnt <= 1;
                m_ar <= ar; m_ai <= ai; m_br <= br; m_bi <= bi; m_wr <= wr; m_wi <= wi;
            end
        end else if (m_cnt == 5) begin
            m_cnt <= 6;
            e1    <= butterfly(m_ar, m_ai, m_br, m_bi, m_wr, m_wi, 1'b1);
            e0    <= butterfly(m_ar, m_ai, m_br, m_bi, m_wr, m_wi, 1'b0);
        end else if (m_cnt == 6) begin
            if (i_ready) m_cnt <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("ready_s1", 64'(rdy1), 64'(m_cnt == 0));
        chk("ready_s0", 64'(rdy0), 64'(m_cnt == 0));
        chk("valid_s1", 64'(vld1), 64'(m_cnt == 6));
        chk("valid_s0", 64'(vld0), 64'(m_cnt == 6));
        chk("data_s1", {xr1, xi1, yr1, yi1}, e1);
        chk("data_s0", {xr0, xi0, yr0, yi0}, e0);
    end

    // Called just after a falling edge; returns at the falling edge after the accept edge.
    task automatic drive(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i);
        ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int lat;
        lat = 0;
        while (!vld1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd5);
    endtask

    task automatic txn(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                       output logic [63:0] r1, output logic [63:0] r0);
        drive(a_r, a_i, b_r, b_i, w_r, w_i);
        wait_valid();
        r1 = {xr1, xi1, yr1, yi1};
        r0 = {xr0, xi0, yr0, yi0};
        @(negedge clk);
    endtask

    logic [63:0] r1, r0;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(rdy1), 64'd1);
        chk("reset_valid", 64'(vld1), 64'd0);
        chk("reset_data", {xr1, xi1, yr1, yi1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        txn(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, r1, r0);
        chk("identity_s1", r1, 64'h0100_0000_0000_0000);

        txn(16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'hFF00, r1, r0);
        chk("twiddle_mj_s1", r1, 64'h0100_FF80_FF00_0080);

        txn(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, r1, r0);
        chk("neg_trunc_s0", r0, 64'hFFFF_0000_0001_0000);

        txn(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, r1, r0);
        chk("sat_pos_s0", r0, 64'h7FFF_0000_0000_0000);

        txn(16'h8100, 16'h0000, 16'h8100, 16'h0000, 16'h0100, 16'h0000, r1, r0);
        chk("sat_neg_s0", r0, 64'h8000_0000_0000_0000);

        // Back-pressure: result must hold while new operands are offered.
        i_ready = 1'b0;
        drive(16'h0010, 16'h0020, 16'h0200, 16'h0100, 16'h0080, 16'h0080);
        wait_valid();
        chk("bp_data_s1", {xr1, xi1, yr1, yi1}, 64'h0048_00D0_FFC8_FF50);
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            ar = ar + 16'h0111; bi = bi - 16'h0033; wr = wr ^ 16'h5A5A;
            @(negedge clk);
            chk("bp_hold_ready", 64'(rdy1), 64'd0);
            chk("bp_hold_data_s1", {xr1, xi1, yr1, yi1}, 64'h0048_00D0_FFC8_FF50);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(rdy1), 64'd1);
        txn(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, r1, r0);
        chk("after_bp_s1", r1, 64'h0100_0000_0000_0000);

        // Reset while in MUL2.
        drive(16'h1234, 16'h0567, 16'h0300, 16'hFD00, 16'h00B5, 16'hFF4B);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(vld1 | vld0), 64'd0);
        chk("midrst_ready", 64'({rdy1, rdy0}), 64'd3);
        chk("midrst_data", {xr1, xi1, yr1, yi1, xr0, xi0, yr0, yi0}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, r1, r0);
        chk("after_rst_s0", r0, 64'hFFFF_0000_0001_0000);

        // Model-only vectors with mixed signs and both twiddle components.
        txn(16'h1234, 16'h0567, 16'h0300, 16'hFD00, 16'h00B5, 16'hFF4B, r1, r0);
        txn(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0100, 16'h0100, r1, r0);
        txn(16'hF0F0, 16'h0F0F, 16'h8000, 16'h8000, 16'h8000, 16'h8000, r1, r0);
        txn(16'h0001, 16'hFFFF, 16'h00FF, 16'hFF01, 16'hFFFF, 16'h0001, r1, r0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
